// File: rtl/net_tx_pkg.sv
// Shared types and default timing constants for the network transmit arbiter.
package net_tx_pkg;

    localparam int unsigned IFG_CYCLES_DEFAULT = 48;
    localparam int unsigned TIMEOUT_DEFAULT    = 1024;
    localparam int unsigned PORT_W             = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_WAIT_TX,
        S_TX,
        S_GAP
    } state_e;

endpackage

// File: rtl/net_tx_arbiter_if.sv
// Requester / network_stack signal bundle for net_tx_arbiter.
// master drives the requests, payload and eth_txen; slave is the arbiter.
interface net_tx_arbiter_if
    import net_tx_pkg::*;
#(
    parameter int unsigned DATA_SIZE = 16
) ();

    logic [1:0]           req;
    logic [1:0]           gnt;
    logic [1:0]           s_valid;
    logic [DATA_SIZE-1:0] s_data0;
    logic [DATA_SIZE-1:0] s_data1;
    logic [PORT_W-1:0]    cfg_port0;
    logic [PORT_W-1:0]    cfg_port1;
    logic                 axiiv;
    logic [DATA_SIZE-1:0] axiid;
    logic [PORT_W-1:0]    udp_dst_port_out;
    logic                 eth_txen;
    logic                 busy;
    logic                 frame_done;
    logic                 err;

    modport master (
        output req, s_valid, s_data0, s_data1, cfg_port0, cfg_port1, eth_txen,
        input  gnt, axiiv, axiid, udp_dst_port_out, busy, frame_done, err
    );

    modport slave (
        input  req, s_valid, s_data0, s_data1, cfg_port0, cfg_port1, eth_txen,
        output gnt, axiiv, axiid, udp_dst_port_out, busy, frame_done, err
    );

endinterface

// File: rtl/net_tx_arbiter.sv
// Two-requester round-robin frame arbiter feeding a UDP network_stack.
// Define NET_TX_ARB_TIMEOUT_EN to abort a frame when eth_txen never rises.
module net_tx_arbiter
    import net_tx_pkg::*;
#(
    parameter int unsigned DATA_SIZE  = 16,
    parameter int unsigned WORDS      = 7,
    parameter int unsigned IFG_CYCLES = IFG_CYCLES_DEFAULT,
    parameter int unsigned TIMEOUT    = TIMEOUT_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    net_tx_arbiter_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(WORDS + 1);
    localparam int unsigned GAP_W = $clog2(IFG_CYCLES + 1);

    state_e               state_q;
    logic [1:0]           gnt_q;
    logic                 sel_q;
    logic                 fav_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [GAP_W-1:0]     gap_q;
    logic                 axiiv_q;
    logic [DATA_SIZE-1:0] axiid_q;
    logic [PORT_W-1:0]    port_q;
    logic                 busy_q;
    logic                 done_q;

    logic                 win_d;
    logic                 valid_d;
    logic [DATA_SIZE-1:0] word_d;

    // fav_q names the requester that wins when both ask at once
    always_comb begin
        win_d   = bus.req[1] & (~bus.req[0] | fav_q);
        valid_d = sel_q ? bus.s_valid[1] : bus.s_valid[0];
        word_d  = sel_q ? bus.s_data1 : bus.s_data0;
    end

`ifdef NET_TX_ARB_TIMEOUT_EN
    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
    logic [TMR_W-1:0] tmr_q;
    logic             err_q;
`else
    // TIMEOUT only matters when the abort path is built
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            sel_q   <= 1'b0;
            fav_q   <= 1'b0;
            cnt_q   <= '0;
            gap_q   <= '0;
            axiiv_q <= 1'b0;
            axiid_q <= '0;
            port_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef NET_TX_ARB_TIMEOUT_EN
            tmr_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            done_q  <= 1'b0;
            axiiv_q <= 1'b0;
`ifdef NET_TX_ARB_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
            unique case (state_q)
                S_IDLE: begin
                    if (|bus.req) begin
                        state_q <= S_GRANT;
                        sel_q   <= win_d;
                        fav_q   <= ~win_d;
                        gnt_q   <= win_d ? 2'b10 : 2'b01;
                        port_q  <= win_d ? bus.cfg_port1 : bus.cfg_port0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_GRANT: begin
                    if (valid_d) begin
                        axiiv_q <= 1'b1;
                        axiid_q <= word_d;
                        cnt_q   <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(WORDS - 1)) begin
                            gnt_q   <= '0;
                            state_q <= S_WAIT_TX;
`ifdef NET_TX_ARB_TIMEOUT_EN
                            tmr_q   <= '0;
`endif
                        end
                    end
                end
                S_WAIT_TX: begin
                    if (bus.eth_txen) begin
                        state_q <= S_TX;
`ifdef NET_TX_ARB_TIMEOUT_EN
                    end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
                        // abandon the frame: no frame_done and no gap
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
`endif
                    end
                end
                S_TX: begin
                    if (!bus.eth_txen) begin
                        state_q <= S_GAP;
                        done_q  <= 1'b1;
                        gap_q   <= '0;
                    end
                end
                S_GAP: begin
                    if (gap_q == GAP_W'(IFG_CYCLES - 1)) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        gap_q   <= '0;
                    end else begin
                        gap_q <= gap_q + GAP_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt              = gnt_q;
    assign bus.axiiv            = axiiv_q;
    assign bus.axiid            = axiid_q;
    assign bus.udp_dst_port_out = port_q;
    assign bus.busy             = busy_q;
    assign bus.frame_done       = done_q;
`ifdef NET_TX_ARB_TIMEOUT_EN
    assign bus.err              = err_q;
`else
    assign bus.err              = 1'b0;
`endif

endmodule

// File: tb/tb_net_tx_arbiter.sv
// Directed bench for net_tx_arbiter with a frame-level reference model
// compared on every cycle, plus hand-computed timing/data expectations.
module tb_net_tx_arbiter;

    localparam int DW    = 16;
    localparam int WORDS = 7;
    localparam int IFG   = 48;
`ifdef NET_TX_ARB_TIMEOUT_EN
    localparam int TMO      = 16;
    localparam int T1_DELAY = 3;
`else
    localparam int TMO      = 1024;
    localparam int T1_DELAY = 40;
`endif
    localparam logic [15:0] CFG0 = 16'h1111;
    localparam logic [15:0] CFG1 = 16'h2222;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    net_tx_arbiter_if #(.DATA_SIZE(DW)) bus ();

    net_tx_arbiter #(
        .DATA_SIZE (DW),
        .WORDS     (WORDS),
        .IFG_CYCLES(IFG),
        .TIMEOUT   (TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h cycle=%0d", name, got, exp, cyc);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i >= 0 && i < q.size()) ? q[i] : -1;
    endfunction

    // ---------------- reference model: frame-level view ----------------
    int          m_owner = -1;
    int          m_sent, m_gap, m_wait, m_fav;
    bit          m_await, m_intx, m_ready;
    logic [1:0]  e_gnt;
    logic        e_axiiv, e_busy, e_fd, e_err;
    logic [15:0] e_axiid, e_port;

    always @(posedge clk) begin
        e_fd    = 1'b0;
        e_err   = 1'b0;
        e_axiiv = 1'b0;
        if (rst) begin
            m_owner = -1; m_sent = 0; m_gap = 0; m_wait = 0; m_fav = 0;
            m_await = 0;  m_intx = 0; m_ready = 1;
            e_axiid = '0; e_port = '0;
        end else if (m_owner >= 0) begin
            if (bus.s_valid[m_owner]) begin
                e_axiiv = 1'b1;
                e_axiid = (m_owner == 1) ? bus.s_data1 : bus.s_data0;
                m_sent++;
                if (m_sent == WORDS) begin
                    m_owner = -1; m_await = 1; m_wait = 0;
                end
            end
        end else if (m_await) begin
            m_wait++;
            if (bus.eth_txen) begin
                m_await = 0; m_intx = 1;
            end
`ifdef NET_TX_ARB_TIMEOUT_EN
            else if (m_wait == TMO) begin
                m_await = 0; e_err = 1'b1;
            end
`endif
        end else if (m_intx) begin
            if (!bus.eth_txen) begin
                m_intx = 0; e_fd = 1'b1; m_gap = IFG;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else if (bus.req != 2'b00) begin
            m_owner = (bus.req == 2'b11) ? m_fav : (bus.req[1] ? 1 : 0);
            m_fav   = 1 - m_owner;
            m_sent  = 0;
            e_port  = (m_owner == 1) ? CFG1 : CFG0;
        end
        e_gnt  = (m_owner < 0) ? 2'b00 : 2'(1 << m_owner);
        e_busy = (m_owner >= 0) || m_await || m_intx || (m_gap > 0);
    end

    // ---------------- per-cycle compare and event log ----------------
    int          fd_count = 0, fd_cyc = -1, busy_fall = -1;
    int          g_req[$], w_cyc[$];
    logic [15:0] words[$];
    logic        prev_busy = 1'b0;
    logic [1:0]  prev_gnt  = 2'b00;

    always @(negedge clk) begin
        if (m_ready) begin
            chk("gnt", bus.gnt, e_gnt);
            chk("axiiv", bus.axiiv, e_axiiv);
            if (e_axiiv) chk("axiid", bus.axiid, e_axiid);
            chk("udp_port", bus.udp_dst_port_out, e_port);
            chk("busy", bus.busy, e_busy);
            chk("frame_done", bus.frame_done, e_fd);
            chk("err", bus.err, e_err);
            if (bus.frame_done) begin fd_count++; fd_cyc = cyc; end
            if (prev_busy && !bus.busy) busy_fall = cyc;
            if (bus.gnt != 2'b00 && prev_gnt == 2'b00) g_req.push_back(bus.gnt[1] ? 1 : 0);
            if (bus.axiiv) begin words.push_back(bus.axiid); w_cyc.push_back(cyc); end
            prev_busy = bus.busy;
            prev_gnt  = bus.gnt;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        fd_count = 0; fd_cyc = -1; busy_fall = -1;
        g_req.delete(); w_cyc.delete(); words.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic set_word(input int r, input logic v, input logic [15:0] d);
        bus.s_valid[r] = v;
        if (r == 0) bus.s_data0 = d;
        else        bus.s_data1 = d;
    endtask

    task automatic wait_gnt(input int r, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bus.gnt[r]) begin ok = 1'b1; break; end
            tick();
        end
        chk(name, 32'(ok), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 200; i++) begin
            if (!bus.busy) break;
            tick();
        end
        chk(name, bus.busy, 1'b0);
    endtask

    task automatic send_words(input int r, input logic [15:0] w[WORDS], input int hole_after);
        int k     = 0;
        bit holed = 1'b0;
        while (k < WORDS) begin
            if (k == hole_after && !holed) begin
                set_word(r, 1'b0, 16'hDEAD);
                holed = 1'b1;
            end else begin
                set_word(r, 1'b1, w[k]);
                k++;
            end
            tick();
        end
        set_word(r, 1'b0, 16'h0000);
    endtask

    task automatic tx_burst(input int delay, input int len, output int fall_cyc);
        repeat (delay) tick();
        bus.eth_txen = 1'b1;
        repeat (len) tick();
        bus.eth_txen = 1'b0;
        fall_cyc = cyc;
    endtask

    logic [15:0] t1w[WORDS] = '{16'hABCD, 16'hBCDE, 16'hCDEF, 16'hDEF0, 16'hEF01, 16'hF012, 16'hFFFF};
    logic [15:0] t2w[WORDS] = '{16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505, 16'h0606, 16'h0707};
    logic [15:0] t3w[WORDS] = '{16'h1A1A, 16'h2B2B, 16'h3C3C, 16'h4D4D, 16'h5E5E, 16'h6F6F, 16'h7070};

    initial begin
        int rc, d0, fall;
        bus.req = 2'b00; bus.s_valid = 2'b00; bus.s_data0 = '0; bus.s_data1 = '0;
        bus.cfg_port0 = CFG0; bus.cfg_port1 = CFG1; bus.eth_txen = 1'b0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;

        // reset values
        chk("rst_gnt", bus.gnt, 2'b00);
        chk("rst_axiiv", bus.axiiv, 1'b0);
        chk("rst_axiid", bus.axiid, 16'h0000);
        chk("rst_port", bus.udp_dst_port_out, 16'h0000);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_frame_done", bus.frame_done, 1'b0);
        chk("rst_err", bus.err, 1'b0);

        // single requester, seven contiguous words
        clear_log();
        bus.req = 2'b01;
        rc = cyc;
        wait_gnt(0, "t1_gnt_seen");
        chk("t1_gnt_latency", 32'(cyc - rc), 32'd1);
        chk("t1_gnt", bus.gnt, 2'b01);
        chk("t1_port", bus.udp_dst_port_out, CFG0);
        bus.req = 2'b00;
        d0 = cyc;
        send_words(0, t1w, -1);
        chk("t1_gnt_clear", bus.gnt, 2'b00);
        set_word(0, 1'b1, 16'h1234);
        tick();
        set_word(0, 1'b0, 16'h0000);
        tick();
        chk("t1_word_count", 32'(words.size()), 32'd7);
        chk("t1_data_latency", 32'(qget(w_cyc, 0) - d0), 32'd1);
        for (int k = 0; k < WORDS; k++)
            chk("t1_word", (k < words.size()) ? 32'(words[k]) : 32'hDEADBEEF, 32'(t1w[k]));
        tx_burst(T1_DELAY, 10, fall);
        wait_idle("t1_idle");
        chk("t1_fd_count", 32'(fd_count), 32'd1);

        // both requesting from reset, hole mid-frame, long transmit
        do_reset();
        clear_log();
        bus.req = 2'b11;
        wait_gnt(0, "t2_first_seen");
        chk("t2_first_gnt", bus.gnt, 2'b01);
        chk("t2_first_port", bus.udp_dst_port_out, CFG0);
        bus.req[0] = 1'b0;
        send_words(0, t2w, 3);
        tx_burst(2, 500, fall);
        chk("t2_words", 32'(words.size()), 32'd7);
        chk("t2_hole_span", 32'(qget(w_cyc, 6) - qget(w_cyc, 0)), 32'd7);
        chk("t2_no_early_gnt", bus.gnt, 2'b00);
        wait_gnt(1, "t2_second_seen");
        chk("t2_regnt_delay", 32'(cyc - fall), 32'd50);
        chk("t2_second_gnt", bus.gnt, 2'b10);
        chk("t2_second_port", bus.udp_dst_port_out, CFG1);
        chk("t2_fd_once", 32'(fd_count), 32'd1);
        chk("t2_busy_after_fd", 32'(busy_fall - fd_cyc), 32'd48);
        bus.req = 2'b00;
        send_words(1, t3w, -1);
        tx_burst(1, 5, fall);
        wait_idle("t2_idle");
        chk("t2_order0", 32'(qget(g_req, 0)), 32'd0);
        chk("t2_order1", 32'(qget(g_req, 1)), 32'd1);
        chk("t2_total_words", 32'(words.size()), 32'd14);
        chk("t2_fd_count", 32'(fd_count), 32'd2);

        // reset during the third word
        do_reset();
        clear_log();
        bus.req = 2'b01;
        wait_gnt(0, "t3_gnt_seen");
        bus.req = 2'b00;
        set_word(0, 1'b1, 16'h0A0A); tick();
        set_word(0, 1'b1, 16'h0B0B); tick();
        set_word(0, 1'b1, 16'h0C0C);
        rst = 1'b1;
        tick();
        chk("t3_rst_gnt", bus.gnt, 2'b00);
        chk("t3_rst_axiiv", bus.axiiv, 1'b0);
        chk("t3_rst_axiid", bus.axiid, 16'h0000);
        chk("t3_rst_port", bus.udp_dst_port_out, 16'h0000);
        chk("t3_rst_busy", bus.busy, 1'b0);
        rst = 1'b0;
        set_word(0, 1'b0, 16'h0000);
        tick(); tick();
        chk("t3_no_fd", 32'(fd_count), 32'd0);
        chk("t3_words_before_rst", 32'(words.size()), 32'd2);
        bus.req = 2'b10;
        wait_gnt(1, "t3_restart_seen");
        chk("t3_restart_gnt", bus.gnt, 2'b10);
        chk("t3_restart_port", bus.udp_dst_port_out, CFG1);
        bus.req = 2'b00;
        send_words(1, t3w, -1);
        tx_burst(1, 4, fall);
        wait_idle("t3_idle");
        chk("t3_fd_count", 32'(fd_count), 32'd1);

`ifdef NET_TX_ARB_TIMEOUT_EN
        // eth_txen never rises: abort after TIMEOUT cycles
        begin
            int entry, err_at;
            clear_log();
            bus.req = 2'b01;
            wait_gnt(0, "t4_gnt_seen");
            bus.req = 2'b00;
            send_words(0, t1w, -1);
            entry  = cyc;
            err_at = -1;
            for (int i = 0; i < 40; i++) begin
                if (bus.err) begin err_at = cyc; break; end
                tick();
            end
            chk("t4_err_delay", 32'(err_at - entry), 32'd16);
            chk("t4_busy", bus.busy, 1'b0);
            tick();
            chk("t4_err_pulse", bus.err, 1'b0);
            chk("t4_no_fd", 32'(fd_count), 32'd0);
        end
`endif

        tick(); tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
